// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial line of the UART transmit framer.
// The master drives the word and request; the slave (framer) drives the line and busy.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output data_valid, p_data, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  data_valid, p_data, par_en, par_typ,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave bus
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          state_d   = START;
          data_d    = bus.p_data;
          par_en_d  = bus.par_en;
          par_typ_d = bus.par_typ;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          state_d = par_en_q ? PARITY : STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d = STOP;
        cnt_d   = '0;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the line is registered with no extra cycle of latency.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[cnt_d];
      PARITY:  tx_d = (^data_d) ^ par_typ_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;
endmodule
